// File: rtl/branch_resolution_queue.sv
// In-order queue of in-flight conditional-branch predictions; emits registered
// predictor feedback and misprediction redirects. Optional counters: BRQ_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;
  typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;
endpackage

module branch_resolution_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_enq_valid,
  input  logic [`ADDR_WIDTH-1:0]       i_enq_pc,
  input  mips_core_pkg::BranchOutcome  i_enq_prediction,
  input  logic [`ADDR_WIDTH-1:0]       i_enq_recovery_target,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [CNT_W-1:0]             o_count,
  input  logic                         i_res_valid,
  input  mips_core_pkg::BranchOutcome  i_res_outcome,
  output logic                         o_fb_valid,
  output logic [`ADDR_WIDTH-1:0]       o_fb_pc,
  output mips_core_pkg::BranchOutcome  o_fb_prediction,
  output mips_core_pkg::BranchOutcome  o_fb_outcome,
  output logic                         o_redirect_valid,
  output logic [`ADDR_WIDTH-1:0]       o_redirect_pc
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]                  o_stat_resolved,
  output logic [31:0]                  o_stat_mispredict
`endif
);
  import mips_core_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [`ADDR_WIDTH-1:0] r_pc [DEPTH];
  BranchOutcome           r_pred [DEPTH];
  logic [`ADDR_WIDTH-1:0] r_rt [DEPTH];

  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_res, w_mis, w_enq, w_write;

  // Enqueue acceptance uses the pre-edge count, so a full queue drops even
  // when a correct resolve frees a slot in the same cycle.
  assign w_res   = i_res_valid && (r_count != '0);
  assign w_mis   = w_res && (r_pred[r_head] != i_res_outcome);
  assign w_enq   = i_enq_valid && (r_count != CNT_W'(DEPTH));
  assign w_write = w_enq && !w_mis && !i_flush && rst_n;

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_pc[r_tail]   <= i_enq_pc;
      r_pred[r_tail] <= i_enq_prediction;
      r_rt[r_tail]   <= i_enq_recovery_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      o_fb_valid       <= 1'b0;
      o_fb_pc          <= '0;
      o_fb_prediction  <= NOT_TAKEN;
      o_fb_outcome     <= NOT_TAKEN;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
    end else begin
      o_fb_valid       <= 1'b0;
      o_redirect_valid <= 1'b0;
      if (i_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_res) begin
          o_fb_valid      <= 1'b1;
          o_fb_pc         <= r_pc[r_head];
          o_fb_prediction <= r_pred[r_head];
          o_fb_outcome    <= i_res_outcome;
        end
        if (w_mis) begin
          // Everything younger than the mispredicted branch is wrong-path.
          o_redirect_valid <= 1'b1;
          o_redirect_pc    <= r_rt[r_head];
          r_head           <= r_head + PTR_W'(1);
          r_tail           <= r_head + PTR_W'(1);
          r_count          <= '0;
        end else begin
          if (w_res) r_head <= r_head + PTR_W'(1);
          if (w_enq) r_tail <= r_tail + PTR_W'(1);
          r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_res);
        end
      end
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_stat_resolved   <= '0;
      o_stat_mispredict <= '0;
    end else if (!i_flush) begin
      if (w_res) o_stat_resolved   <= o_stat_resolved + 32'd1;
      if (w_mis) o_stat_mispredict <= o_stat_mispredict + 32'd1;
    end
  end
`endif

  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: doc/branch_resolution_queue.md
# branch_resolution_queue

In-order queue of in-flight conditional-branch predictions between decode and execute. Each prediction issued at decode is stored with its PC and recovery target. When execute resolves the branch, the head entry is popped and two things are emitted one cycle later: registered training feedback (valid/pc/prediction/outcome) for the predictor, and a misprediction redirect to fetch. Entries younger than a mispredicted branch are discarded.

## Interface
Parameters:
- DEPTH, 4 — number of entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1) — occupancy width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- i_flush  in  1  external full flush (exception/redirect from later stage)
- i_enq_valid  in  1  decode issues a conditional-branch prediction (valid & ~is_jump, stage advancing)
- i_enq_pc  in  `ADDR_WIDTH  branch PC
- i_enq_prediction  in  mips_core_pkg::BranchOutcome  predicted direction
- i_enq_recovery_target  in  `ADDR_WIDTH  PC to fetch if prediction is wrong
- o_full  out  1  count == DEPTH; decode must stall enqueues
- o_empty  out  1  count == 0
- o_count  out  CNT_W  occupancy
- i_res_valid  in  1  execute resolves the oldest outstanding conditional branch
- i_res_outcome  in  mips_core_pkg::BranchOutcome  actual direction
- o_fb_valid  out  1  one-cycle feedback pulse to predictor
- o_fb_pc  out  `ADDR_WIDTH  resolved branch PC
- o_fb_prediction  out  BranchOutcome  stored prediction
- o_fb_outcome  out  BranchOutcome  actual outcome
- o_redirect_valid  out  1  one-cycle misprediction redirect pulse
- o_redirect_pc  out  `ADDR_WIDTH  stored recovery target

## Operation
- Storage: circular buffer of DEPTH entries {pc, prediction, recovery_target}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is a separate CNT_W register.
- Update priority per edge: ~rst_n > i_flush > mispredict > normal.
- Resolve: if i_res_valid and count>0, pop the head. Mispredict = (stored prediction != i_res_outcome).
- Mispredict: pop the head, discard every younger entry (tail = head+1, count = 0), and drop any same-cycle enqueue.
- Enqueue: if i_enq_valid and count<DEPTH (evaluated on the pre-edge count), write at tail and increment tail.
- Enqueue while full is dropped silently. This holds even if a correct resolve happens in the same cycle; decode must honour o_full.
- Same-cycle correct resolve plus accepted enqueue: count unchanged, both pointers advance.
- Resolve while empty: ignored, and no feedback or redirect is emitted. This includes same-cycle enqueue into an empty queue: the new entry is not yet resolvable.
- i_flush: head = tail = 0, count = 0. Resolve, enqueue and output pulses in that cycle are all suppressed.
- Entry payloads are not cleared on reset or flush; only pointers and count are cleared.

## Timing
- Reset values: o_fb_valid=0, o_redirect_valid=0, o_fb_pc=0, o_redirect_pc=0, o_fb_prediction=NOT_TAKEN, o_fb_outcome=NOT_TAKEN, o_count=0, o_empty=1, o_full=0.
- Feedback and redirect are registered. They pulse for exactly one cycle, in the cycle after the accepted i_res_valid edge.
- o_fb_* data holds its last value while o_fb_valid=0. o_redirect_pc holds its last value while o_redirect_valid=0.
- Every accepted resolve produces o_fb_valid; o_redirect_valid is produced only on a mispredict.
- o_full, o_empty and o_count are driven from registers, with no combinational path from the i_* inputs.
- Enqueue-to-resolvable latency: 1 cycle, so the entry can be resolved on the next edge.
- Back-to-back resolves, one per cycle, produce back-to-back feedback pulses.

## Configuration
- BRQ_STATS_EN defined: adds outputs o_stat_resolved and o_stat_mispredict, each 32 bits. They increment on each accepted resolve and each mispredict, wrap at 2^32, reset to 0, and are not cleared by i_flush.
- BRQ_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then enqueue PC 0x100 (TAKEN, rt 0x108), then resolve TAKEN → next cycle o_fb_valid=1, pc=0x100, pred=outcome=TAKEN, o_redirect_valid=0, count=0.
- Enqueue 0x200 (NOT_TAKEN, rt 0x400), 0x210 and 0x220, then resolve TAKEN → o_redirect_valid=1, o_redirect_pc=0x400, o_fb_pc=0x200, count=0; a following resolve produces no feedback.
- Fill with DEPTH=4 entries → o_full=1. Then assert enqueue plus a correct resolve together → count stays 3, the dropped entry never appears in feedback.
- Issue 10 enqueue/resolve pairs so the pointers wrap → feedback PCs emerge in enqueue order, with no loss or duplication.
- i_flush with 3 entries queued and i_res_valid also high → count=0, no fb/redirect pulse. Deassert rst_n mid-stream → all outputs at their reset values on the next edge.
- With BRQ_STATS_EN, run 5 resolves including 2 mispredicts → o_stat_resolved=5, o_stat_mispredict=2, unchanged after i_flush.
